// File: rtl/rv32i_pkg.sv
// rv32i_pkg: funct3 load/store size codes and the memory-side FSM state type
// shared by the data-memory responder and the load/store unit.
package rv32i_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_e;
endpackage

// File: rtl/dmem_responder_array.sv
// dmem_array: DEPTH x 32 synchronous memory with per-byte write enables and
// a registered read port that only updates when en is high.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: rv32i data-memory responder with request/response handshakes,
// byte/half/word strobes and load extension; DMEM_ERR_EN reports misalignment.
module dmem_responder
    import rv32i_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
    mem_state_e state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic we_q;
    logic [2:0] size_q;
    logic [AW+1:0] addr_q;
    logic [31:0] wdata_q, wlanes, rd, ext;
    logic [15:0] shifted;
    logic [3:0] strb;
    logic [1:0] lane;
    logic accept, access, is_b, is_h, is_w, mis, unused_addr;
    assign unused_addr = ^req_addr[31:AW+2];
    assign req_ready = (state == IDLE) && rst_n;
    assign accept = req_valid && req_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            we_q <= 1'b0;
            size_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            if (accept) begin
                we_q <= req_we;
                size_q <= req_size;
                addr_q <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
            end
        end
    end
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        access = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_nxt = BUSY;
                cnt_nxt = 4'(LATENCY - 1);
            end
            BUSY: if (cnt == 4'd0) begin
                access = 1'b1;
                state_nxt = RESP;
            end else cnt_nxt = cnt - 4'd1;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    assign is_b = (size_q == F3_B) || (size_q == F3_BU);
    assign is_h = (size_q == F3_H) || (size_q == F3_HU);
    assign is_w = !is_b && !is_h;
`ifdef DMEM_ERR_EN
    assign mis = (is_h && addr_q[0]) || (is_w && (addr_q[1:0] != 2'b00));
    assign lane = addr_q[1:0];
`else
    // Misaligned halves/words are silently snapped down to their natural boundary.
    assign mis = 1'b0;
    assign lane = is_w ? 2'b00 : is_h ? {addr_q[1], 1'b0} : addr_q[1:0];
`endif
    assign strb = (!we_q || mis) ? 4'b0000 :
                  is_b ? 4'b0001 << lane :
                  is_h ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wlanes = is_b ? {4{wdata_q[7:0]}} : is_h ? {2{wdata_q[15:0]}} : wdata_q;
    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .en    (access),
        .we    (strb),
        .idx   (addr_q[AW+1:2]),
        .wdata (wlanes),
        .rdata (rd)
    );
    assign shifted = 16'(rd >> {lane, 3'b000});
    assign ext = is_w ? rd :
                 is_b ? {{24{shifted[7] & ~size_q[2]}}, shifted[7:0]} :
                        {{16{shifted[15] & ~size_q[2]}}, shifted};
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = (rsp_valid && !we_q && !mis) ? ext : 32'd0;
    assign rsp_err = rsp_valid && mis;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table-driven bench for dmem_responder, with a
// LATENCY=1 instance for function and a LATENCY=4 instance for timing/abort cases.
module tb_dmem_responder;
    import rv32i_pkg::*;
`ifdef DMEM_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid [2];
    logic req_ready [2];
    logic req_we [2];
    logic [2:0] req_size [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic rsp_valid [2];
    logic rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic rsp_err [2];
    int n_cmp = 0;
    int n_fail = 0;
    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );
    dmem_responder #(.DEPTH(1024), .LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    typedef struct {
        logic we;
        logic [2:0] size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic err;
    } vec_t;
    vec_t v [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic xfer(input int s, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
        int w;
        w = 0;
        while (!req_ready[s] && w < 30) begin
            @(posedge clk); #1; w++;
        end
        if (w == 30) chk("req_ready_timeout", 32'(req_ready[s]), 32'd1);
        req_we[s] = we; req_size[s] = size; req_addr[s] = addr; req_wdata[s] = wdata;
        req_valid[s] = 1'b1;
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        lat = 0;
        while (!rsp_valid[s] && lat < 30) begin
            if (req_ready[s]) chk("req_ready_busy", 32'(req_ready[s]), 32'd0);
            @(posedge clk); #1; lat++;
        end
        rdata = rsp_rdata[s];
        err = rsp_err[s];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid[s]), 32'd1);
            chk("hold_rdata", rsp_rdata[s], rdata);
            chk("hold_req_ready", 32'(req_ready[s]), 32'd0);
        end
        rsp_ready[s] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[s] = 1'b0;
        if (rsp_valid[s]) chk("rsp_drop", 32'(rsp_valid[s]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int lat;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 0; req_we[s] = 0; req_size[s] = 0;
            req_addr[s] = 0; req_wdata[s] = 0; rsp_ready[s] = 0;
        end
        v[0]  = '{1'b1, F3_W,   32'h10,   32'hDEADBEEF, 32'h0, 1'b0};
        v[1]  = '{1'b0, F3_W,   32'h10,   32'h0, 32'hDEADBEEF, 1'b0};
        v[2]  = '{1'b0, F3_B,   32'h13,   32'h0, 32'hFFFFFFDE, 1'b0};
        v[3]  = '{1'b0, F3_BU,  32'h13,   32'h0, 32'h000000DE, 1'b0};
        v[4]  = '{1'b0, F3_H,   32'h12,   32'h0, 32'hFFFFDEAD, 1'b0};
        v[5]  = '{1'b0, F3_HU,  32'h10,   32'h0, 32'h0000BEEF, 1'b0};
        v[6]  = '{1'b0, F3_B,   32'h10,   32'h0, 32'hFFFFFFEF, 1'b0};
        v[7]  = '{1'b0, F3_BU,  32'h11,   32'h0, 32'h000000BE, 1'b0};
        v[8]  = '{1'b0, 3'b011, 32'h10,   32'h0, 32'hDEADBEEF, 1'b0};
        v[9]  = '{1'b0, F3_W,   32'h12,   32'h0, ERR ? 32'h0 : 32'hDEADBEEF, ERR};
        v[10] = '{1'b1, F3_H,   32'h11,   32'h0000FFFF, 32'h0, ERR};
        v[11] = '{1'b0, F3_W,   32'h10,   32'h0, ERR ? 32'hDEADBEEF : 32'hDEADFFFF, 1'b0};
        v[12] = '{1'b1, F3_W,   32'h10,   32'hDEADBEEF, 32'h0, 1'b0};
        v[13] = '{1'b1, F3_B,   32'h11,   32'h12345655, 32'h0, 1'b0};
        v[14] = '{1'b0, F3_W,   32'h10,   32'h0, 32'hDEAD55EF, 1'b0};
        v[15] = '{1'b1, F3_W,   32'h14,   32'h11223344, 32'h0, 1'b0};
        v[16] = '{1'b1, F3_H,   32'h16,   32'hCAFE8001, 32'h0, 1'b0};
        v[17] = '{1'b0, F3_W,   32'h14,   32'h0, 32'h80013344, 1'b0};
        v[18] = '{1'b0, F3_H,   32'h16,   32'h0, 32'hFFFF8001, 1'b0};
        v[19] = '{1'b0, F3_B,   32'h15,   32'h0, 32'h00000033, 1'b0};
        v[20] = '{1'b1, 3'b111, 32'h18,   32'hCAFEBABE, 32'h0, 1'b0};
        v[21] = '{1'b0, F3_W,   32'h18,   32'h0, 32'hCAFEBABE, 1'b0};
        v[22] = '{1'b1, F3_W,   32'h1010, 32'h0, 32'h0, 1'b0};
        v[23] = '{1'b0, F3_W,   32'h10,   32'h0, 32'h0, 1'b0};
        #12;
        chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
        chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_req_ready", 32'(req_ready[0]), 32'd1);
        for (int i = 0; i < 24; i++) begin
            xfer(0, v[i].we, v[i].size, v[i].addr, v[i].wdata, 0, rd, er, lat);
            chk($sformatf("v%0d_rdata", i), rd, v[i].rdata);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(v[i].err));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
        end
        xfer(1, 1'b1, F3_W, 32'h20, 32'hA5A5A5A5, 0, rd, er, lat);
        chk("l4_sw_latency", 32'(lat), 32'd4);
        xfer(1, 1'b0, F3_W, 32'h20, 32'h0, 5, rd, er, lat);
        chk("l4_lw_latency", 32'(lat), 32'd4);
        chk("l4_lw_rdata", rd, 32'hA5A5A5A5);
        req_we[1] = 1'b1; req_size[1] = F3_W; req_addr[1] = 32'h20; req_wdata[1] = 32'h11111111;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_req_ready", 32'(req_ready[1]), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("abort_rsp_rdata", rsp_rdata[1], 32'd0);
        chk("abort_rsp_err", 32'(rsp_err[1]), 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, F3_W, 32'h20, 32'h0, 0, rd, er, lat);
        chk("abort_mem_kept", rd, 32'hA5A5A5A5);
        chk("abort_lw_latency", 32'(lat), 32'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
